frame_xform_engine: RTL and testbench

- Parametrised successor to the single-mode adapter; buffers one W x H frame of RGB pixels in on-chip RAM, then streams it out transformed.
- Supports identity, rotate 90/180/270, horizontal/vertical mirror and transpose.
- Adds valid/ready handshakes on both sides, non-square frames and explicit frame/line markers.
- Sits between the pixel source (SRAM loader) and the output writer.

---
 rtl/frame_xform_engine_pkg.sv | 27 ++
 rtl/frame_xform_engine_if.sv | 24 ++
 rtl/frame_xform_engine_addr_gen.sv | 81 ++++++++
 rtl/frame_xform_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_frame_xform_engine.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_xform_engine_pkg.sv
// Shared constants for the frame transform engine: transform modes, FSM
// encoding and the CRC-32 polynomial with a single-bit update helper.
package frame_xform_pkg;

   localparam logic [2:0] MODE_ID   = 3'b000;
   localparam logic [2:0] MODE_R90  = 3'b001;
   localparam logic [2:0] MODE_R180 = 3'b010;
   localparam logic [2:0] MODE_R270 = 3'b011;
   localparam logic [2:0] MODE_MIRH = 3'b100;
   localparam logic [2:0] MODE_MIRV = 3'b101;
   localparam logic [2:0] MODE_TRN  = 3'b110;
   localparam logic [2:0] MODE_ILL  = 3'b111;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;

   localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

   // Shift one message bit into a non-reflected CRC-32 register.
   function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic din);
      logic fb;
      fb = crc[31] ^ din;
      return fb ? ({crc[30:0], 1'b0} ^ CRC_POLY) : {crc[30:0], 1'b0};
   endfunction

endpackage

// File: rtl/frame_xform_engine_if.sv
// Pixel stream bundle for the frame transform engine: input stream and
// output stream with row/frame markers. The engine takes the slave side.
interface frame_xform_engine_if #(
   parameter int PIX_W = 24
);
   logic             in_valid;
   logic             in_ready;
   logic [PIX_W-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [PIX_W-1:0] out_data;
   logic             out_eol;
   logic             out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_eol, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_eol, out_last
   );
endinterface

// File: rtl/frame_xform_engine_addr_gen.sv
// Output raster walker: row/column counters over the transformed frame,
// mapped back to a linear source address, plus end-of-row/frame flags.
module xform_addr_gen
   import frame_xform_pkg::*;
#(
   parameter int IMG_W  = 1024,
   parameter int IMG_H  = 1024,
   parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              step,
   input  logic [2:0]        mode,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              eol,
   output logic              last,
   output logic              done
);
   localparam int DIM_W = $clog2((IMG_W > IMG_H ? IMG_W : IMG_H) + 1);

   logic [DIM_W-1:0] row_reg;
   logic [DIM_W-1:0] col_reg;
   logic             done_reg;
   logic [DIM_W-1:0] ow_m1;
   logic [DIM_W-1:0] oh_m1;
   logic             swap;
   int unsigned      r32;
   int unsigned      c32;
   int unsigned      sr;
   int unsigned      sc;

   // Rotations by 90/270 and transpose exchange the output dimensions.
   assign swap  = (mode == MODE_R90) || (mode == MODE_R270) || (mode == MODE_TRN);
   assign ow_m1 = swap ? DIM_W'(IMG_H - 1) : DIM_W'(IMG_W - 1);
   assign oh_m1 = swap ? DIM_W'(IMG_W - 1) : DIM_W'(IMG_H - 1);

   always_comb begin
      r32 = 32'(row_reg);
      c32 = 32'(col_reg);
      sr  = r32;
      sc  = c32;
      case (mode)
         MODE_R90:  begin sr = IMG_H - 1 - c32; sc = r32;             end
         MODE_R180: begin sr = IMG_H - 1 - r32; sc = IMG_W - 1 - c32; end
         MODE_R270: begin sr = c32;             sc = IMG_W - 1 - r32; end
         MODE_MIRH: begin sr = r32;             sc = IMG_W - 1 - c32; end
         MODE_MIRV: begin sr = IMG_H - 1 - r32; sc = c32;             end
         MODE_TRN:  begin sr = c32;             sc = r32;             end
         default:   begin sr = r32;             sc = c32;             end
      endcase
   end

   assign rd_addr = ADDR_W'(sr * IMG_W + sc);
   assign eol     = (col_reg == ow_m1);
   assign last    = eol && (row_reg == oh_m1);
   assign done    = done_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_reg  <= '0;
         col_reg  <= '0;
         done_reg <= 1'b0;
      end else if (clear) begin
         row_reg  <= '0;
         col_reg  <= '0;
         done_reg <= 1'b0;
      end else if (step) begin
         if (eol) begin
            col_reg <= '0;
            row_reg <= row_reg + 1'b1;
         end else begin
            col_reg <= col_reg + 1'b1;
         end
         if (last) begin
            done_reg <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/frame_xform_engine.sv
// Frame buffer + transform streamer: loads one raster frame, then replays it
// rotated/mirrored/transposed through a 2-entry skid buffer. FRAME_XFORM_CRC_EN adds out_crc.
module frame_xform_engine
   import frame_xform_pkg::*;
#(
   parameter int PIX_W  = 24,
   parameter int IMG_W  = 1024,
   parameter int IMG_H  = 1024,
   parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [2:0]          op_mode,
   output logic                busy,
   output logic                mode_err,
   output logic                frame_done,
   frame_xform_engine_if.slave px
`ifdef FRAME_XFORM_CRC_EN
   ,
   output logic [31:0]         out_crc
`endif
);
   localparam int NPIX = IMG_W * IMG_H;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

   logic [1:0]        state_reg;
   logic [2:0]        mode_reg;
   logic              busy_reg;
   logic              mode_err_reg;
   logic              frame_done_reg;
   logic [ADDR_W-1:0] wr_addr_reg;

   logic [PIX_W-1:0]  mem [NPIX];
   logic [PIX_W-1:0]  rd_data_reg;
   logic              rd_pend_reg;
   logic              rd_eol_reg;
   logic              rd_last_reg;

   logic [PIX_W-1:0]  skid_data_reg [2];
   logic              skid_eol_reg  [2];
   logic              skid_last_reg [2];
   logic [1:0]        skid_cnt_reg;

   logic              start_ok;
   logic              wr_en;
   logic              issue;
   logic              pop;
   logic              frame_end;
   logic [2:0]        occ;
   logic [ADDR_W-1:0] gen_addr;
   logic              gen_eol;
   logic              gen_last;
   logic              gen_done;

   assign start_ok  = (state_reg == ST_IDLE) && start && (op_mode != MODE_ILL);
   assign wr_en     = (state_reg == ST_LOAD) && px.in_valid;
   assign pop       = px.out_valid && px.out_ready;
   assign frame_end = pop && skid_last_reg[0];

   // Occupancy after this cycle's pop, counting the read still in the RAM pipe.
   assign occ   = 3'(skid_cnt_reg) + 3'(rd_pend_reg) - 3'(pop);
   assign issue = (state_reg == ST_STREAM) && !gen_done && (occ < 3'd2);

   assign busy          = busy_reg;
   assign mode_err      = mode_err_reg;
   assign frame_done    = frame_done_reg;
   assign px.in_ready   = (state_reg == ST_LOAD);
   assign px.out_valid  = (skid_cnt_reg != 2'd0);
   assign px.out_data   = skid_data_reg[0];
   assign px.out_eol    = px.out_valid && skid_eol_reg[0];
   assign px.out_last   = px.out_valid && skid_last_reg[0];

   xform_addr_gen #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk     (clk),
      .rst     (rst),
      .clear   (start_ok),
      .step    (issue),
      .mode    (mode_reg),
      .rd_addr (gen_addr),
      .eol     (gen_eol),
      .last    (gen_last),
      .done    (gen_done)
   );

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr_reg] <= px.in_data;
      end
      if (issue) begin
         rd_data_reg <= mem[gen_addr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         mode_reg       <= MODE_ID;
         busy_reg       <= 1'b0;
         mode_err_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
         wr_addr_reg    <= '0;
      end else begin
         mode_err_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start && (op_mode == MODE_ILL)) begin
                  mode_err_reg <= 1'b1;
               end else if (start_ok) begin
                  mode_reg    <= op_mode;
                  busy_reg    <= 1'b1;
                  wr_addr_reg <= '0;
                  state_reg   <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (wr_en) begin
                  wr_addr_reg <= wr_addr_reg + 1'b1;
                  if (wr_addr_reg == LAST_ADDR) begin
                     state_reg <= ST_STREAM;
                  end
               end
            end
            ST_STREAM: begin
               if (frame_end) begin
                  busy_reg       <= 1'b0;
                  frame_done_reg <= 1'b1;
                  state_reg      <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Skid buffer: entry 0 is the head presented on the output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_pend_reg      <= 1'b0;
         rd_eol_reg       <= 1'b0;
         rd_last_reg      <= 1'b0;
         skid_cnt_reg     <= 2'd0;
         skid_data_reg[0] <= '0;
         skid_data_reg[1] <= '0;
         skid_eol_reg[0]  <= 1'b0;
         skid_eol_reg[1]  <= 1'b0;
         skid_last_reg[0] <= 1'b0;
         skid_last_reg[1] <= 1'b0;
      end else begin
         rd_pend_reg <= issue;
         if (issue) begin
            rd_eol_reg  <= gen_eol;
            rd_last_reg <= gen_last;
         end
         if (frame_end) begin
            skid_cnt_reg <= 2'd0;
         end else begin
            case ({rd_pend_reg, pop})
               2'b10: begin
                  if (skid_cnt_reg == 2'd0) begin
                     skid_data_reg[0] <= rd_data_reg;
                     skid_eol_reg[0]  <= rd_eol_reg;
                     skid_last_reg[0] <= rd_last_reg;
                  end else begin
                     skid_data_reg[1] <= rd_data_reg;
                     skid_eol_reg[1]  <= rd_eol_reg;
                     skid_last_reg[1] <= rd_last_reg;
                  end
                  skid_cnt_reg <= skid_cnt_reg + 2'd1;
               end
               2'b01: begin
                  skid_data_reg[0] <= skid_data_reg[1];
                  skid_eol_reg[0]  <= skid_eol_reg[1];
                  skid_last_reg[0] <= skid_last_reg[1];
                  skid_cnt_reg     <= skid_cnt_reg - 2'd1;
               end
               2'b11: begin
                  if (skid_cnt_reg == 2'd1) begin
                     skid_data_reg[0] <= rd_data_reg;
                     skid_eol_reg[0]  <= rd_eol_reg;
                     skid_last_reg[0] <= rd_last_reg;
                  end else begin
                     skid_data_reg[0] <= skid_data_reg[1];
                     skid_eol_reg[0]  <= skid_eol_reg[1];
                     skid_last_reg[0] <= skid_last_reg[1];
                     skid_data_reg[1] <= rd_data_reg;
                     skid_eol_reg[1]  <= rd_eol_reg;
                     skid_last_reg[1] <= rd_last_reg;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef FRAME_XFORM_CRC_EN
   logic [31:0] crc_reg;
   logic [31:0] crc_next;

   always_comb begin
      crc_next = crc_reg;
      for (int i = PIX_W - 1; i >= 0; i--) begin
         crc_next = crc32_bit(crc_next, px.out_data[i]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         crc_reg <= '0;
      end else if (start_ok) begin
         crc_reg <= 32'hFFFFFFFF;
      end else if (pop) begin
         crc_reg <= crc_next;
      end
   end

   assign out_crc = crc_reg;
`endif

endmodule

// File: tb/tb_frame_xform_engine.sv
// Directed bench for frame_xform_engine on a 4x3 frame: every transform,
// stalls and input gaps, illegal mode, mid-stream reset and optional CRC.
module tb_frame_xform_engine;
   localparam int PIX_W = 24;
   localparam int IMG_W = 4;
   localparam int IMG_H = 3;
   localparam int NPIX  = IMG_W * IMG_H;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [2:0] op_mode = 3'b000;
   logic       busy;
   logic       mode_err;
   logic       frame_done;
`ifdef FRAME_XFORM_CRC_EN
   logic [31:0] out_crc;
`endif

   int checks = 0;
   int errors = 0;
   int in_hs  = 0;

   logic [23:0] exp_r90  [NPIX] = '{8, 4, 0, 9, 5, 1, 10, 6, 2, 11, 7, 3};
   logic [23:0] exp_r180 [NPIX] = '{11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
   logic [23:0] exp_mirh [NPIX] = '{3, 2, 1, 0, 7, 6, 5, 4, 11, 10, 9, 8};
   logic [23:0] exp_mirv [NPIX] = '{8, 9, 10, 11, 4, 5, 6, 7, 0, 1, 2, 3};
   logic [23:0] exp_trn  [NPIX] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
   logic [23:0] exp_id   [NPIX] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
   logic [23:0] exp_r270 [NPIX] = '{3, 7, 11, 2, 6, 10, 1, 0, 0, 0, 0, 0};

   frame_xform_engine_if #(.PIX_W(PIX_W)) px ();

   frame_xform_engine #(
      .PIX_W (PIX_W),
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .op_mode    (op_mode),
      .busy       (busy),
      .mode_err   (mode_err),
      .frame_done (frame_done),
      .px         (px)
`ifdef FRAME_XFORM_CRC_EN
      ,
      .out_crc    (out_crc)
`endif
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) begin
      if (px.in_valid && px.in_ready) in_hs <= in_hs + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] crc_ref(input int n);
      logic [31:0] crc;
      logic [23:0] d;
      logic        fb;
      crc = 32'hFFFFFFFF;
      for (int p = 0; p < n; p++) begin
         d = 24'(p);
         for (int b = 23; b >= 0; b--) begin
            fb  = crc[31] ^ d[b];
            crc = {crc[30:0], 1'b0};
            if (fb) crc = crc ^ 32'h04C11DB7;
         end
      end
      return crc;
   endfunction

   task automatic do_start(input logic [2:0] m, input string nm);
      @(negedge clk);
      start   = 1'b1;
      op_mode = m;
      @(negedge clk);
      start   = 1'b0;
      op_mode = 3'b111;
      chk({nm, "_busy_after_start"}, 32'(busy), 1);
      $display("start mode=%0d busy=%0b", m, busy);
   endtask

   task automatic load_frame(input bit gaps, input string nm);
      int i = 0;
      int cyc = 0;
      int hs0;
      hs0 = in_hs;
      while (i < NPIX && cyc < 200) begin
         @(negedge clk);
         cyc++;
         px.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         px.in_data  = 24'(i);
         if (px.in_valid && px.in_ready) i++;
      end
      chk({nm, "_load_count"}, 32'(i), NPIX);
      @(negedge clk);
      px.in_valid = 1'b1;
      px.in_data  = 24'hBAD;
      chk({nm, "_excess_ready1"}, 32'(px.in_ready), 0);
      chk({nm, "_valid_early1"}, 32'(px.out_valid), 0);
      @(negedge clk);
      chk({nm, "_excess_ready2"}, 32'(px.in_ready), 0);
      chk({nm, "_valid_early2"}, 32'(px.out_valid), 0);
      @(negedge clk);
      px.in_valid = 1'b0;
      chk({nm, "_first_valid"}, 32'(px.out_valid), 1);
      chk({nm, "_in_handshakes"}, 32'(in_hs - hs0), NPIX);
      $display("load %s handshakes=%0d", nm, in_hs - hs0);
   endtask

   task automatic run_frame(input logic [23:0] exp_px [NPIX], input int ow, input int nstop,
                            input bit stall, input string nm);
      int idx = 0;
      int cyc = 0;
      int fd = 0;
      logic held_v = 1'b0;
      logic [23:0] held_d = '0;
      while (idx < nstop && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (held_v) begin
            chk({nm, "_hold_valid"}, 32'(px.out_valid), 1);
            chk({nm, "_hold_data"}, 32'(px.out_data), 32'(held_d));
         end
         if (frame_done) fd++;
         px.out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (px.out_valid && px.out_ready) begin
            chk({nm, "_data"}, 32'(px.out_data), 32'(exp_px[idx]));
            chk({nm, "_eol"}, 32'(px.out_eol), 32'((idx % ow) == (ow - 1)));
            chk({nm, "_last"}, 32'(px.out_last), 32'(idx == NPIX - 1));
            $display("out %s idx=%0d data=%0h eol=%0b last=%0b", nm, idx, px.out_data,
                     px.out_eol, px.out_last);
            idx++;
            held_v = 1'b0;
         end else begin
            held_v = px.out_valid;
            held_d = px.out_data;
         end
      end
      chk({nm, "_pixel_count"}, 32'(idx), 32'(nstop));
      if (nstop == NPIX) begin
         @(negedge clk);
         px.out_ready = 1'b0;
         chk({nm, "_frame_done"}, 32'(frame_done), 1);
         chk({nm, "_busy_drop"}, 32'(busy), 0);
         chk({nm, "_no_extra_valid"}, 32'(px.out_valid), 0);
         @(negedge clk);
         chk({nm, "_frame_done_pulse"}, 32'(frame_done), 0);
         chk({nm, "_early_frame_done"}, 32'(fd), 0);
      end
   endtask

   initial begin
      px.in_valid  = 1'b0;
      px.in_data   = '0;
      px.out_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mode_err", 32'(mode_err), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_in_ready", 32'(px.in_ready), 0);
      chk("rst_out_valid", 32'(px.out_valid), 0);
      chk("rst_out_eol", 32'(px.out_eol), 0);
      chk("rst_out_last", 32'(px.out_last), 0);
      @(negedge clk);
      rst = 1'b1;

      @(negedge clk);
      start   = 1'b1;
      op_mode = 3'b111;
      @(negedge clk);
      start = 1'b0;
      chk("ill_mode_err", 32'(mode_err), 1);
      chk("ill_busy", 32'(busy), 0);
      chk("ill_in_ready", 32'(px.in_ready), 0);
      @(negedge clk);
      chk("ill_mode_err_pulse", 32'(mode_err), 0);
      chk("ill_busy2", 32'(busy), 0);
      chk("ill_in_ready2", 32'(px.in_ready), 0);
      $display("illegal start mode_err pulse checked");

      do_start(3'b001, "r90");
      load_frame(1'b0, "r90");
      run_frame(exp_r90, 3, NPIX, 1'b0, "r90");

      do_start(3'b010, "r180");
      load_frame(1'b0, "r180");
      run_frame(exp_r180, 4, NPIX, 1'b0, "r180");

      do_start(3'b100, "mirh");
      load_frame(1'b0, "mirh");
      run_frame(exp_mirh, 4, NPIX, 1'b0, "mirh");

      do_start(3'b110, "trn");
      load_frame(1'b0, "trn");
      run_frame(exp_trn, 3, NPIX, 1'b0, "trn");

      do_start(3'b101, "mirv");
      load_frame(1'b0, "mirv");
      run_frame(exp_mirv, 4, NPIX, 1'b1, "mirv");

      do_start(3'b000, "id_stall");
      load_frame(1'b1, "id_stall");
      run_frame(exp_id, 4, NPIX, 1'b1, "id_stall");

      do_start(3'b011, "r270");
      load_frame(1'b0, "r270");
      run_frame(exp_r270, 3, 7, 1'b0, "r270");
      @(negedge clk);
      rst = 1'b0;
      px.out_ready = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("midrst_busy", 32'(busy), 0);
         chk("midrst_out_valid", 32'(px.out_valid), 0);
         chk("midrst_frame_done", 32'(frame_done), 0);
         @(negedge clk);
      end
      rst = 1'b1;
      $display("mid-stream reset released");

      do_start(3'b000, "id_fresh");
      load_frame(1'b0, "id_fresh");
      run_frame(exp_id, 4, NPIX, 1'b0, "id_fresh");

`ifdef FRAME_XFORM_CRC_EN
      for (int f = 0; f < 2; f++) begin
         do_start(3'b000, "crc");
         load_frame(1'b0, "crc");
         run_frame(exp_id, 4, NPIX, 1'b0, "crc");
         chk("crc_value", out_crc, crc_ref(NPIX));
         $display("crc frame=%0d out_crc=%08h", f, out_crc);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
